// File: rtl/adc_sample_buffer.sv
// Averages 2^avgLog2 validated ADC samples per channel and queues each average,
// tagged with its channel, in a first-word-fall-through FIFO drained by valid/ready.
module adc_sample_buffer #(
  parameter int dataWidth     = 12,
  parameter int avgLog2       = 2,
  parameter int fifoDepth     = 16,
  parameter int fifoAddrWidth = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              frameWord,
  input  logic                     frameValid,
  input  logic                     signedMode,
  input  logic [7:0]               channelMask,
  input  logic                     clearFlags,
  output logic [dataWidth-1:0]     sampleData,
  output logic [2:0]               sampleChannel,
  output logic                     sampleValid,
  input  logic                     sampleReady,
  output logic [fifoAddrWidth:0]   fifoCount,
  output logic                     overflow,
  output logic                     frameError
);

  localparam int CntWidth   = (avgLog2 > 0) ? avgLog2 : 1;
  localparam int AccWidth   = dataWidth + avgLog2;
  localparam int EntryWidth = dataWidth + 3;
  localparam logic [CntWidth-1:0]    CntLast   = CntWidth'((1 << avgLog2) - 1);
  localparam logic [fifoAddrWidth:0] CountFull = (fifoAddrWidth + 1)'(fifoDepth);

  logic [AccWidth-1:0]      r_acc [8];
  logic [CntWidth-1:0]      r_cnt [8];
  logic                     r_signed_prev;
  logic [EntryWidth-1:0]    r_mem [fifoDepth];
  logic [fifoAddrWidth-1:0] r_wptr;
  logic [fifoAddrWidth-1:0] r_rptr;
  logic [fifoAddrWidth:0]   r_count;
  logic                     r_overflow;
  logic                     r_frame_error;

  logic [2:0]               w_ch;
  logic [dataWidth-1:0]     w_d;
  logic                     w_frame_bad;
  logic                     w_accept;
  logic                     w_mode_chg;
  logic [AccWidth-1:0]      w_acc_cur;
  logic [CntWidth-1:0]      w_cnt_cur;
  logic [AccWidth-1:0]      w_ext;
  logic [AccWidth-1:0]      w_sum;
  logic [AccWidth-1:0]      w_shifted;
  logic [dataWidth-1:0]     w_avg;
  logic                     w_last;
  logic                     w_push_req;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_push;
  logic                     w_drop;
  logic [EntryWidth-1:0]    w_head;

  // A signedMode change in this cycle makes the incoming frame the first of a fresh window.
  always_comb begin
    w_ch        = frameWord[14:12];
    w_d         = frameWord[dataWidth-1:0];
    w_frame_bad = frameValid & enable & frameWord[15];
    w_accept    = frameValid & enable & ~frameWord[15] & channelMask[w_ch];
    w_mode_chg  = signedMode ^ r_signed_prev;
    if (w_mode_chg) begin
      w_acc_cur = '0;
      w_cnt_cur = '0;
    end else begin
      w_acc_cur = r_acc[w_ch];
      w_cnt_cur = r_cnt[w_ch];
    end
    if (signedMode) begin
      w_ext = AccWidth'($signed(w_d));
    end else begin
      w_ext = AccWidth'(w_d);
    end
    w_sum = w_acc_cur + w_ext;
    if (signedMode) begin
      w_shifted = $signed(w_sum) >>> avgLog2;
    end else begin
      w_shifted = w_sum >> avgLog2;
    end
    w_avg      = w_shifted[dataWidth-1:0];
    w_last     = (w_cnt_cur == CntLast);
    w_push_req = w_accept & w_last;
    w_pop      = (r_count != '0) & sampleReady;
    w_full     = (r_count == CountFull);
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
  end

  // Per-channel accumulators and sample counts.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_signed_prev <= 1'b0;
    end else begin
      r_signed_prev <= signedMode;
      if (w_mode_chg) begin
        for (int i = 0; i < 8; i++) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
        end
      end
      if (w_accept) begin
        if (w_last) begin
          r_acc[w_ch] <= '0;
          r_cnt[w_ch] <= '0;
        end else begin
          r_acc[w_ch] <= w_sum;
          r_cnt[w_ch] <= w_cnt_cur + CntWidth'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while empty because the outputs are gated.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_ch, w_avg};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + fifoAddrWidth'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + fifoAddrWidth'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (fifoAddrWidth + 1)'(1);
        2'b01:   r_count <= r_count - (fifoAddrWidth + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags; a set condition beats a simultaneous clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clearFlags) begin
        r_overflow <= 1'b0;
      end
      if (w_frame_bad) begin
        r_frame_error <= 1'b1;
      end else if (clearFlags) begin
        r_frame_error <= 1'b0;
      end
    end
  end

  assign w_head        = r_mem[r_rptr];
  assign sampleValid   = (r_count != '0);
  assign sampleData    = sampleValid ? w_head[dataWidth-1:0] : '0;
  assign sampleChannel = sampleValid ? w_head[EntryWidth-1:dataWidth] : 3'd0;
  assign fifoCount     = r_count;
  assign overflow      = r_overflow;
  assign frameError    = r_frame_error;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Drives three buffers (avgLog2 = 0, 1, 2) with shared stimulus and checks each
// against a queue-based averaging model, plus directed scenario checks.
module tb_adc_sample_buffer;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic [15:0] frameWord;
  logic        frameValid;
  logic        signedMode;
  logic [7:0]  channelMask;
  logic        clearFlags;
  logic        sampleReady;

  logic [11:0] o_data  [3];
  logic [2:0]  o_ch    [3];
  logic        o_valid [3];
  logic [4:0]  o_count [3];
  logic        o_ovf   [3];
  logic        o_ferr  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one instance per averaging depth (k == avgLog2).
  int         m_acc  [3][8];
  int         m_cnt  [3][8];
  logic [14:0] m_q   [3][$];
  bit         m_ovf  [3];
  bit         m_ferr [3];
  bit         m_prev_signed;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_sample_buffer #(
      .dataWidth(12), .avgLog2(g), .fifoDepth(16), .fifoAddrWidth(4)
    ) u_dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
      .frameWord(frameWord), .frameValid(frameValid), .signedMode(signedMode),
      .channelMask(channelMask), .clearFlags(clearFlags),
      .sampleData(o_data[g]), .sampleChannel(o_ch[g]), .sampleValid(o_valid[g]),
      .sampleReady(sampleReady), .fifoCount(o_count[g]),
      .overflow(o_ovf[g]), .frameError(o_ferr[g])
    );
  end

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[k=%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_step();
    int         v;
    int         win;
    int         avg;
    logic [2:0] ch;
    bit         do_push;
    bit         do_pop;
    logic [14:0] item;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int c = 0; c < 8; c++) begin
          m_acc[k][c] = 0;
          m_cnt[k][c] = 0;
        end
        m_q[k].delete();
        m_ovf[k]  = 1'b0;
        m_ferr[k] = 1'b0;
      end else begin
        win     = 1 << k;
        do_push = 1'b0;
        item    = '0;
        do_pop  = (m_q[k].size() > 0) && sampleReady;
        if (signedMode != m_prev_signed) begin
          for (int c = 0; c < 8; c++) begin
            m_acc[k][c] = 0;
            m_cnt[k][c] = 0;
          end
        end
        if (clearFlags) begin
          m_ovf[k]  = 1'b0;
          m_ferr[k] = 1'b0;
        end
        if (frameValid && enable) begin
          if (frameWord[15]) begin
            m_ferr[k] = 1'b1;
          end else begin
            ch = frameWord[14:12];
            if (channelMask[ch]) begin
              if (signedMode) v = $signed(frameWord[11:0]);
              else            v = int'(frameWord[11:0]);
              m_acc[k][ch] += v;
              m_cnt[k][ch] += 1;
              if (m_cnt[k][ch] == win) begin
                avg = m_acc[k][ch] >>> k;
                item = {ch, 12'(avg)};
                do_push = 1'b1;
                m_acc[k][ch] = 0;
                m_cnt[k][ch] = 0;
              end
            end
          end
        end
        if (do_pop) void'(m_q[k].pop_front());
        if (do_push) begin
          if (m_q[k].size() < 16) m_q[k].push_back(item);
          else                    m_ovf[k] = 1'b1;
        end
      end
    end
    m_prev_signed = reset ? 1'b0 : signedMode;
  endtask

  task automatic check_all();
    logic [14:0] head;
    bit          nonempty;
    for (int k = 0; k < 3; k++) begin
      nonempty = (m_q[k].size() > 0);
      head     = nonempty ? m_q[k][0] : 15'd0;
      chk("valid", k, 32'(o_valid[k]), 32'(nonempty));
      chk("data",  k, 32'(o_data[k]),  32'(head[11:0]));
      chk("chan",  k, 32'(o_ch[k]),    32'(head[14:12]));
      chk("count", k, 32'(o_count[k]), 32'(m_q[k].size()));
      chk("ovf",   k, 32'(o_ovf[k]),   32'(m_ovf[k]));
      chk("ferr",  k, 32'(o_ferr[k]),  32'(m_ferr[k]));
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    check_all();
  endtask

  task automatic send(input logic [15:0] w);
    frameWord  = w;
    frameValid = 1'b1;
    tick();
    frameValid = 1'b0;
  endtask

  task automatic drain();
    sampleReady = 1'b1;
    repeat (20) tick();
    sampleReady = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; frameWord = 16'h0000; frameValid = 1'b0;
    signedMode = 1'b0; channelMask = 8'hFF; clearFlags = 1'b0; sampleReady = 1'b0;
    m_prev_signed = 1'b0;
    tick();
    tick();
    chk("rst_valid", 2, 32'(o_valid[2]), 32'd0);
    chk("rst_count", 2, 32'(o_count[2]), 32'd0);
    reset = 1'b0;
    tick();

    // Unsigned average of four samples on channel 3.
    send(16'h3064); send(16'h3065); send(16'h3066); send(16'h3067);
    chk("tp1_data", 2, 32'(o_data[2]), 32'd101);
    chk("tp1_chan", 2, 32'(o_ch[2]), 32'd3);
    chk("tp1_count", 2, 32'(o_count[2]), 32'd1);
    drain();

    // Signed floor average: (-1 -2 +1 +0) >>> 2 = -1.
    signedMode = 1'b1;
    tick();
    send(16'h0FFF); send(16'h0FFE); send(16'h0001); send(16'h0000);
    chk("tp2_data", 2, 32'(o_data[2]), 32'hFFF);
    drain();

    // Bad frame, then a masked-out channel.
    send(16'h8123);
    chk("tp3_ferr", 2, 32'(o_ferr[2]), 32'd1);
    channelMask = 8'hFD;
    send(16'h1123);
    chk("tp3_masked", 0, 32'(o_count[0]), 32'd0);
    channelMask = 8'hFF;
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    chk("tp3_clr", 2, 32'(o_ferr[2]), 32'd0);

    // Pass-through fill to overflow, then push+pop while full.
    signedMode = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) send({1'b0, 3'(i), 12'(i * 100 + 1)});
    chk("tp4_count", 0, 32'(o_count[0]), 32'd16);
    chk("tp4_ovf", 0, 32'(o_ovf[0]), 32'd1);
    chk("tp4_head", 0, 32'(o_data[0]), 32'd1);
    sampleReady = 1'b1;
    send({1'b0, 3'd1, 12'd1701});
    sampleReady = 1'b0;
    chk("tp4_pp_count", 0, 32'(o_count[0]), 32'd16);
    chk("tp4_pp_ovf", 0, 32'(o_ovf[0]), 32'd1);
    chk("tp4_pp_head", 0, 32'(o_data[0]), 32'd101);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    drain();

    // Reset mid-window on channels 2 and 5.
    send(16'h2FFF); send(16'h5FFF);
    reset = 1'b1;
    frameWord = 16'h2FFF; frameValid = 1'b1; sampleReady = 1'b1; clearFlags = 1'b1;
    tick();
    frameValid = 1'b0; sampleReady = 1'b0; clearFlags = 1'b0;
    chk("tp5_rst_valid", 1, 32'(o_valid[1]), 32'd0);
    chk("tp5_rst_data", 1, 32'(o_data[1]), 32'd0);
    reset = 1'b0;
    send(16'h2010); send(16'h5100); send(16'h2020); send(16'h5300);
    chk("tp5_head", 1, 32'(o_data[1]), 32'd24);
    chk("tp5_chan", 1, 32'(o_ch[1]), 32'd2);
    chk("tp5_count", 1, 32'(o_count[1]), 32'd2);
    drain();

    // signedMode toggle discards a partial window on channel 4.
    send(16'h4100); send(16'h4100); send(16'h4100);
    signedMode = 1'b1;
    tick();
    chk("tp6_none", 2, 32'(o_count[2]), 32'd0);
    send(16'h4004); send(16'h4004); send(16'h4004);
    chk("tp6_not_yet", 2, 32'(o_count[2]), 32'd0);
    send(16'h4004);
    chk("tp6_one", 2, 32'(o_count[2]), 32'd1);
    chk("tp6_data", 2, 32'(o_data[2]), 32'd4);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 149) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      frameValid  = ($urandom_range(0, 3) != 0);
      frameWord   = {($urandom_range(0, 15) == 0), 15'($urandom)};
      if ($urandom_range(0, 39) == 0) signedMode = ~signedMode;
      channelMask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      sampleReady = (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      clearFlags  = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
